fnd_distance_display: RTL and testbench

Downstream consumer of the SR04 controller's distance output (cm, 0..400). Converts the binary distance to BCD with a sequential double-dabble engine. Drives a 4-digit multiplexed common-anode FND with leading-zero blanking and an over-range indication. Scan timing is derived from the shared 1 us tick.

---
 rtl/fnd_distance_display_pkg.sv | 77 +++++++
 rtl/fnd_distance_display_bin2bcd.sv | 124 ++++++++++++
 rtl/fnd_distance_display.sv | 146 ++++++++++++++
 tb/tb_fnd_distance_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_distance_display_pkg.sv
// Shared definitions for the distance FND display.
// Holds the converter state encoding, segment codes, digit-enable patterns
// and small encode helpers.
package fnd_pkg;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LATCH = 2'd2
  } conv_state_t;

  // Common-anode segment codes {dp,g,f,e,d,c,b,a}, active-low
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Digit enables, active-low one-hot; bit0 is the units digit
  localparam logic [3:0] COM_OFF  = 4'b1111;
  localparam logic [3:0] COM_DIG0 = 4'b1110;
  localparam logic [3:0] COM_DIG1 = 4'b1101;
  localparam logic [3:0] COM_DIG2 = 4'b1011;
  localparam logic [3:0] COM_DIG3 = 4'b0111;

  // BCD nibble to segment code; anything outside 0..9 is blanked
  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Scan index to digit-enable pattern
  function automatic logic [3:0] com_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COM_DIG0;
      2'd1:    pat = COM_DIG1;
      2'd2:    pat = COM_DIG2;
      2'd3:    pat = COM_DIG3;
      default: pat = COM_OFF;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // after the next doubling, so bias it by 3 first
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_distance_display_bin2bcd.sv
// Sequential double-dabble engine: one shift per clock, DIST_W shifts per
// conversion. The result and over-range flag are written only in LATCH and
// announced by a registered one-clock done pulse on the following clock.
module dist_bin2bcd
  import fnd_pkg::*;
#(
  parameter int DIST_W = 9,
  parameter int MAX_CM = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIST_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [11:0]       bcd,
  output logic              over
);

  localparam int                CNT_W      = $clog2(DIST_W + 1);
  localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DIST_W - 1);
  localparam logic [DIST_W-1:0] MAX_VAL    = DIST_W'(MAX_CM);

  conv_state_t       state_r;
  conv_state_t       state_nxt_s;
  logic [DIST_W-1:0] src_r;
  logic [11:0]       bcd_r;
  logic [11:0]       adj_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              over_cap_r;
  logic [11:0]       bcd_out_r;
  logic              over_out_r;
  logic              done_r;
  logic              busy_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= CONV_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT for DIST_W clocks, LATCH once
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CONV_IDLE: begin
        if (start) begin
          state_nxt_s = CONV_SHIFT;
        end else begin
          state_nxt_s = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        if (cnt_r == LAST_SHIFT) begin
          state_nxt_s = CONV_LATCH;
        end else begin
          state_nxt_s = CONV_SHIFT;
        end
      end
      CONV_LATCH: state_nxt_s = CONV_IDLE;
      default:    state_nxt_s = CONV_IDLE;
    endcase
  end

  // Output decode: busy covers the whole SHIFT and LATCH span
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      CONV_SHIFT: busy_s = 1'b1;
      CONV_LATCH: busy_s = 1'b1;
      default:    busy_s = 1'b0;
    endcase
  end

  // Per-nibble add-3 correction applied before each shift
  always_comb begin
    adj_s = {dd_adjust(bcd_r[11:8]), dd_adjust(bcd_r[7:4]), dd_adjust(bcd_r[3:0])};
  end

  // Datapath: capture on start, shift in SHIFT, publish result in LATCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_r      <= '0;
      bcd_r      <= 12'd0;
      cnt_r      <= '0;
      over_cap_r <= 1'b0;
      bcd_out_r  <= 12'd0;
      over_out_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state_r == CONV_LATCH);
      case (state_r)
        CONV_IDLE: begin
          if (start) begin
            src_r      <= bin;
            bcd_r      <= 12'd0;
            cnt_r      <= '0;
            over_cap_r <= (bin > MAX_VAL);
          end
        end
        CONV_SHIFT: begin
          {bcd_r, src_r} <= {adj_s[10:0], src_r, 1'b0};
          cnt_r          <= cnt_r + CNT_W'(1);
        end
        CONV_LATCH: begin
          bcd_out_r  <= bcd_r;
          over_out_r <= over_cap_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy = busy_s;
  assign done = done_r;
  assign bcd  = bcd_out_r;
  assign over = over_out_r;

endmodule

// File: rtl/fnd_distance_display.sv
// Distance display top: detects a changed distance, runs the BCD
// converter, stores the finished digits and scans a 4-digit common-anode
// FND with leading-zero blanking and a dash pattern for over-range.
module fnd_distance_display
  import fnd_pkg::*;
#(
  parameter int DIST_W  = 9,
  parameter int MAX_CM  = 400,
  parameter int SCAN_US = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick_1us,
  input  logic [DIST_W-1:0] distance,
  output logic [3:0]        fnd_com,
  output logic [7:0]        fnd_data,
  output logic              conv_busy
);

  localparam int               TCNT_W    = $clog2(SCAN_US);
  localparam logic [TCNT_W-1:0] SCAN_LAST = TCNT_W'(SCAN_US - 1);

  logic [DIST_W-1:0] last_val_r;
  logic              start_s;
  logic              busy_s;
  logic              done_s;
  logic [11:0]       bcd_s;
  logic              over_s;
  logic [3:0]        dig_h_r;
  logic [3:0]        dig_t_r;
  logic [3:0]        dig_u_r;
  logic              over_r;
  logic [TCNT_W-1:0] tick_cnt_r;
  logic [1:0]        idx_r;
  logic [7:0]        seg_s;
  logic [3:0]        fnd_com_r;
  logic [7:0]        fnd_data_r;

  // Start a conversion only while idle; a change seen while busy is picked
  // up afterwards because the compare is against the last captured value
  always_comb begin
    start_s = 1'b0;
    if (!busy_s && (distance != last_val_r)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Remember the value handed to the converter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val_r <= '0;
    end else if (start_s) begin
      last_val_r <= distance;
    end
  end

  dist_bin2bcd #(
    .DIST_W (DIST_W),
    .MAX_CM (MAX_CM)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (distance),
    .busy  (busy_s),
    .done  (done_s),
    .bcd   (bcd_s),
    .over  (over_s)
  );

  // Displayed digits change only when a finished conversion is reported
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_h_r <= 4'd0;
      dig_t_r <= 4'd0;
      dig_u_r <= 4'd0;
      over_r  <= 1'b0;
    end else if (done_s) begin
      dig_h_r <= bcd_s[11:8];
      dig_t_r <= bcd_s[7:4];
      dig_u_r <= bcd_s[3:0];
      over_r  <= over_s;
    end
  end

  // Digit dwell counter and scan index, advanced by the 1 us tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (i_tick_1us) begin
      if (tick_cnt_r == SCAN_LAST) begin
        tick_cnt_r <= '0;
        idx_r      <= idx_r + 2'd1;
      end else begin
        tick_cnt_r <= tick_cnt_r + TCNT_W'(1);
      end
    end
  end

  // Segment pattern for the digit currently selected, with blanking
  always_comb begin
    seg_s = SEG_BLANK;
    if (over_r) begin
      seg_s = SEG_DASH;
    end else begin
      case (idx_r)
        2'd0: seg_s = seg_encode(dig_u_r);
        2'd1: begin
          if ((dig_h_r == 4'd0) && (dig_t_r == 4'd0)) begin
            seg_s = SEG_BLANK;
          end else begin
            seg_s = seg_encode(dig_t_r);
          end
        end
        2'd2: begin
          if (dig_h_r == 4'd0) begin
            seg_s = SEG_BLANK;
          end else begin
            seg_s = seg_encode(dig_h_r);
          end
        end
        2'd3:    seg_s = SEG_BLANK;
        default: seg_s = SEG_BLANK;
      endcase
    end
  end

  // Registered FND drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fnd_com_r  <= COM_OFF;
      fnd_data_r <= SEG_BLANK;
    end else begin
      fnd_com_r  <= com_pattern(idx_r);
      fnd_data_r <= seg_s;
    end
  end

  assign fnd_com   = fnd_com_r;
  assign fnd_data  = fnd_data_r;
  assign conv_busy = busy_s;

endmodule

// File: tb/tb_fnd_distance_display.sv
// Directed testbench for fnd_distance_display: scan order and dwell,
// conversion latency, blanking, over-range dashes, back-to-back change and
// reset during conversion.
`timescale 1ns/1ps
module tb_fnd_distance_display;

  localparam int TB_SCAN = 100;            // ticks per digit
  localparam int TICK_DIV = 3;             // one tick every 3 clocks
  localparam int DWELL = TB_SCAN * TICK_DIV;

  logic       clk;
  logic       rst;
  logic       i_tick_1us;
  logic [8:0] distance;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  logic       conv_busy;

  int checks;
  int failures;

  fnd_distance_display #(
    .DIST_W  (9),
    .MAX_CM  (400),
    .SCAN_US (TB_SCAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick_1us (i_tick_1us),
    .distance   (distance),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data),
    .conv_busy  (conv_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 us tick stand-in: one-clock pulse every TICK_DIV clocks
  initial begin
    int tdiv;
    tdiv = 0;
    i_tick_1us = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      i_tick_1us = (tdiv == TICK_DIV - 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the start of a units-digit dwell
  task automatic wait_units_start();
    logic [3:0] prev;
    bit found;
    prev = fnd_com;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      if (prev != 4'b1110 && fnd_com == 4'b1110) found = 1'b1;
      prev = fnd_com;
    end
    if (!found) chk("align_timeout", fnd_com, 4'b1110);
  endtask

  // Apply a new distance during the units dwell; check busy length and the
  // exact edge at which the units segment changes
  task automatic run_conv(input string tag, input logic [8:0] v,
                          input logic [7:0] old_u, input logic [7:0] new_u);
    int busy_cnt;
    wait_units_start();
    @(negedge clk);
    distance = v;
    busy_cnt = 0;
    for (int k = 0; k <= 12; k++) begin
      step();
      if (conv_busy) busy_cnt++;
      if (k == 11) chk({tag, "_u_before"}, fnd_data, old_u);
      if (k == 12) chk({tag, "_u_after"}, fnd_data, new_u);
    end
    chk({tag, "_busy_len"}, busy_cnt, 10);
  endtask

  // Sweep one scan frame and check each digit position's segments
  task automatic check_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    logic [3:0] seen;
    seen = 4'h0;
    for (int n = 0; n < 3000 && seen != 4'hF; n++) begin
      step();
      case (fnd_com)
        4'b1110: if (!seen[0]) begin chk({tag, "_d0"}, fnd_data, e0); seen[0] = 1'b1; end
        4'b1101: if (!seen[1]) begin chk({tag, "_d1"}, fnd_data, e1); seen[1] = 1'b1; end
        4'b1011: if (!seen[2]) begin chk({tag, "_d2"}, fnd_data, e2); seen[2] = 1'b1; end
        4'b0111: if (!seen[3]) begin chk({tag, "_d3"}, fnd_data, e3); seen[3] = 1'b1; end
        default: chk({tag, "_com_onehot"}, fnd_com, 4'b1110);
      endcase
    end
    if (seen != 4'hF) chk({tag, "_frame_timeout"}, seen, 4'hF);
  endtask

  initial begin
    logic [3:0] prev;
    int changes;
    int len;
    int busy_cnt;
    bit busy_seen;

    checks = 0;
    failures = 0;
    rst = 1'b0;
    distance = 9'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_com", fnd_com, 4'b1111);
    chk("rst_data", fnd_data, 8'hFF);
    chk("rst_busy", conv_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("first_com", fnd_com, 4'b1110);
    chk("first_data", fnd_data, 8'hC0);

    // Idle with distance 0: scan order, dwell and blanking, no conversion
    prev = fnd_com;
    changes = 0;
    len = 0;
    busy_seen = 1'b0;
    for (int n = 0; n < 3000 && changes < 5; n++) begin
      step();
      len++;
      if (conv_busy) busy_seen = 1'b1;
      if (fnd_com != prev) begin
        chk("scan_order", fnd_com, {prev[2:0], prev[3]});
        chk("idle_seg", fnd_data, (fnd_com == 4'b1110) ? 8'hC0 : 8'hFF);
        if (changes > 0) chk("dwell", len, DWELL);
        changes++;
        len = 0;
        prev = fnd_com;
      end
    end
    if (changes < 5) chk("scan_timeout", changes, 5);
    chk("idle_busy", busy_seen, 1'b0);

    run_conv("d123", 9'd123, 8'hC0, 8'hB0);
    check_frame("f123", 8'hFF, 8'hF9, 8'hA4, 8'hB0);
    run_conv("d7", 9'd7, 8'hB0, 8'hF8);
    check_frame("f7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    run_conv("d400", 9'd400, 8'hF8, 8'hC0);
    check_frame("f400", 8'hFF, 8'h99, 8'hC0, 8'hC0);
    run_conv("d450", 9'd450, 8'hC0, 8'hBF);
    check_frame("f450", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    run_conv("d401", 9'd401, 8'hBF, 8'hBF);
    check_frame("f401", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    run_conv("d400b", 9'd400, 8'hBF, 8'hC0);
    check_frame("f400b", 8'hFF, 8'h99, 8'hC0, 8'hC0);

    // Change to 45 while 123 is still shifting
    wait_units_start();
    @(negedge clk);
    distance = 9'd123;
    for (int k = 0; k <= 23; k++) begin
      step();
      if (k == 2) begin
        @(negedge clk);
        distance = 9'd45;
      end
      if (k == 9)  chk("chg_busy_k9", conv_busy, 1'b1);
      if (k == 10) chk("chg_idle_gap", conv_busy, 1'b0);
      if (k == 11) chk("chg_restart", conv_busy, 1'b1);
      if (k == 11) chk("chg_u_old", fnd_data, 8'hC0);
      if (k == 12) chk("chg_u_123", fnd_data, 8'hB0);
      if (k == 20) chk("chg_busy2_end", conv_busy, 1'b1);
      if (k == 21) chk("chg_idle2", conv_busy, 1'b0);
      if (k == 22) chk("chg_u_hold", fnd_data, 8'hB0);
      if (k == 23) chk("chg_u_45", fnd_data, 8'h92);
    end
    check_frame("f45", 8'hFF, 8'hFF, 8'h99, 8'h92);

    // Reset in the middle of converting 250
    @(negedge clk);
    distance = 9'd250;
    repeat (4) step();
    chk("mid_busy", conv_busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_com", fnd_com, 4'b1111);
    chk("mid_rst_data", fnd_data, 8'hFF);
    chk("mid_rst_busy", conv_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();
    chk("rel_com", fnd_com, 4'b1110);
    chk("rel_data", fnd_data, 8'hC0);
    busy_cnt = conv_busy ? 1 : 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (conv_busy) busy_cnt++;
    end
    chk("rel_busy_len", busy_cnt, 10);
    check_frame("f250", 8'hFF, 8'hA4, 8'h92, 8'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
